mem_port_ctrl: RTL and testbench
================================

MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, word-address width of the SRAM ports.
REQ-002 SHALL have parameter DATA_W, default 64, data width; mask width = DATA_W/8.
REQ-003 SHALL have parameter IMPL_W, default 7, implemented word-address bits; higher bits must be zero.
REQ-004 clock  input  1  sole clock; also wired to the SRAM W0_clk and R0_clk at top level.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  request accepted when valid&&ready.
REQ-008 req_write  input  1  1=write, 0=read.
REQ-009 req_addr  input  ADDR_W  word address.
REQ-010 req_data  input  DATA_W  write data.
REQ-011 req_mask  input  DATA_W/8  byte-write enables.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  response consumed when valid&&ready.
REQ-014 rsp_data  output  DATA_W  read data; zero for writes and errors.
REQ-015 rsp_write  output  1  response belongs to a write.
REQ-016 rsp_err  output  1  address out of implemented range.
REQ-017 W0_addr/W0_en/W0_data/W0_mask  output  ADDR_W/1/DATA_W/DATA_W/8  SRAM write port.
REQ-018 R0_addr/R0_en  output  ADDR_W/1  SRAM read port; R0_data  input  DATA_W, valid the cycle after R0_en.

Function
REQ-019 Accept = req_valid && req_ready; at most one request per cycle.
REQ-020 Error = req_addr[ADDR_W-1:IMPL_W] nonzero; errored requests SHALL NOT assert W0_en or R0_en.
REQ-021 Accepted non-error write: W0_en=1, W0_addr/data/mask = request fields, same cycle, combinationally.
REQ-022 Accepted non-error read: R0_en=1, R0_addr=req_addr, same cycle; W0_en=0.
REQ-023 W0_en and R0_en SHALL never both be 1; idle cycles drive both 0.
REQ-024 Every accepted request SHALL load a one-entry in-flight stage (write, err flags) at the accepting edge.
REQ-025 Response FIFO depth 2, occupancy 0..2, strictly in acceptance order.
REQ-026 Head: FIFO head when occupancy>0, else the in-flight stage with rsp_data = R0_data (reads) presented directly.
REQ-027 rsp_valid = occupancy>0 || inflight; minimum latency: response visible the cycle after acceptance.
REQ-028 In-flight not consumed that cycle SHALL be pushed into the FIFO with R0_data captured that cycle.
REQ-029 req_ready = (occupancy + inflight) < 2, independent of rsp_ready.
REQ-030 With rsp_ready held 1, SHALL sustain one request per cycle indefinitely.
REQ-031 Simultaneous push and pop SHALL leave occupancy unchanged; pop when empty or push when full SHALL not occur by construction.
REQ-032 rsp_* SHALL hold stable while rsp_valid && !rsp_ready.
REQ-033 Write-then-read to the same address on consecutive cycles SHALL return the written data (no forwarding needed).

Reset
REQ-034 On reset_n low: occupancy=0, inflight=0, rsp_valid=0, req_ready=1 after release, W0_en=0, R0_en=0.
REQ-035 Reset mid-operation SHALL discard in-flight and queued responses; no SRAM access until a new accept.
REQ-036 FIFO data storage needs no reset.

Structure
REQ-037 Shared package: response entry typedef {data, write, err}, default ADDR_W/DATA_W/IMPL_W constants.
REQ-038 One sub-module: mem_rsp_fifo (2-entry, valid/ready, occupancy output).

Verification
REQ-039 Write addr 0x05, data 0xDEADBEEF_CAFEF00D, mask 0xFF; read 0x05 next cycle -> W0_en then R0_en one cycle each; read rsp_data 0xDEADBEEF_CAFEF00D, rsp_write=0, rsp_err=0.
REQ-040 Mask 0x0F write of 0x11111111_22222222 over 0 -> read returns 0x00000000_22222222.
REQ-041 Read addr 0x80 -> no R0_en; rsp_err=1, rsp_data=0, one cycle after accept.
REQ-042 rsp_ready=0, three back-to-back reads -> only two accepted, req_ready=0 third cycle; release -> responses in order, then third accepted.
REQ-043 rsp_ready=1, 16 consecutive reads -> req_ready never drops, 16 responses on consecutive cycles.
REQ-044 reset_n pulsed low with two queued responses -> rsp_valid=0 immediately, req_ready=1 after release, no stale response.

Source files
------------

// File: rtl/mem_port_ctrl_pkg.sv
// rtl/mem_port_ctrl_pkg.sv - shared constants and response entry type for the SRAM port controller
package mem_port_ctrl_pkg;

  localparam int DEF_ADDR_W = 25;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_IMPL_W = 7;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  write;
    logic                  err;
  } rsp_entry_t;

  // Writes and errored requests never carry data back.
  function automatic rsp_entry_t make_entry(input logic [DEF_DATA_W-1:0] data,
                                            input logic write, input logic err);
    rsp_entry_t e;
    e.data  = (write || err) ? '0 : data;
    e.write = write;
    e.err   = err;
    return e;
  endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// rtl/mem_rsp_fifo.sv - two-entry response FIFO with valid/ready pop side and occupancy output
module mem_rsp_fifo
  import mem_port_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_push_valid,
  output logic       o_push_ready,
  input  rsp_entry_t i_push_entry,
  output logic       o_pop_valid,
  input  logic       i_pop_ready,
  output rsp_entry_t o_pop_entry,
  output logic [1:0] o_occupancy
);

  rsp_entry_t r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  assign o_push_ready = (r_count != 2'd2);
  assign o_pop_valid  = (r_count != 2'd0);
  assign o_pop_entry  = r_mem[r_rd_ptr];
  assign o_occupancy  = r_count;

  assign w_push = i_push_valid && o_push_ready;
  assign w_pop  = o_pop_valid && i_pop_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is only ever read behind a valid count, so it carries no reset.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_entry;
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - request/response front end for a 1W1R SRAM macro
module mem_port_ctrl
  import mem_port_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMPL_W = DEF_IMPL_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_data,
  input  logic [DATA_W/8-1:0] req_mask,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_write,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   W0_addr,
  output logic                W0_en,
  output logic [DATA_W-1:0]   W0_data,
  output logic [DATA_W/8-1:0] W0_mask,
  output logic [ADDR_W-1:0]   R0_addr,
  output logic                R0_en,
  input  logic [DATA_W-1:0]   R0_data
);

  logic       r_if_valid;
  logic       r_if_write;
  logic       r_if_err;
  logic       w_err;
  logic       w_accept;
  logic       w_if_take;
  logic       w_push;
  logic       w_fifo_valid;
  logic       w_fifo_push_ready;
  logic [1:0] w_occ;
  rsp_entry_t w_if_entry;
  rsp_entry_t w_fifo_head;
  rsp_entry_t w_head;

  assign w_err = |req_addr[ADDR_W-1:IMPL_W];

  // Outstanding responses (queued plus in flight) are capped at two; reset holds the port closed.
  assign req_ready = reset_n && (r_if_valid ? (w_occ == 2'd0) : w_fifo_push_ready);
  assign w_accept  = req_valid && req_ready;

  assign W0_en   = w_accept && req_write && !w_err;
  assign W0_addr = req_addr;
  assign W0_data = req_data;
  assign W0_mask = req_mask;
  assign R0_en   = w_accept && !req_write && !w_err;
  assign R0_addr = req_addr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_if_valid <= 1'b0;
      r_if_write <= 1'b0;
      r_if_err   <= 1'b0;
    end else begin
      r_if_valid <= w_accept;
      if (w_accept) begin
        r_if_write <= req_write;
        r_if_err   <= w_err;
      end
    end
  end

  // R0_data is only valid this cycle, so an unconsumed in-flight response is parked in the FIFO now.
  assign w_if_entry = make_entry(R0_data, r_if_write, r_if_err);
  assign w_if_take  = r_if_valid && !w_fifo_valid && rsp_ready;
  assign w_push     = r_if_valid && !w_if_take;

  mem_rsp_fifo u_rsp_fifo (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_push_valid (w_push),
    .o_push_ready (w_fifo_push_ready),
    .i_push_entry (w_if_entry),
    .o_pop_valid  (w_fifo_valid),
    .i_pop_ready  (rsp_ready),
    .o_pop_entry  (w_fifo_head),
    .o_occupancy  (w_occ)
  );

  assign w_head    = w_fifo_valid ? w_fifo_head : w_if_entry;
  assign rsp_valid = w_fifo_valid || r_if_valid;
  assign rsp_data  = w_head.data;
  assign rsp_write = w_head.write;
  assign rsp_err   = w_head.err;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb/tb_mem_port_ctrl.sv - self-checking bench for mem_port_ctrl against a queue-based reference model
module tb_mem_port_ctrl;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [24:0] req_addr;
  logic [63:0] req_data;
  logic [7:0]  req_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_write;
  logic        rsp_err;
  logic [24:0] W0_addr;
  logic        W0_en;
  logic [63:0] W0_data;
  logic [7:0]  W0_mask;
  logic [24:0] R0_addr;
  logic        R0_en;
  logic [63:0] R0_data;

  mem_port_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_write(rsp_write), .rsp_err(rsp_err),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural SRAM macro: read data appears the cycle after R0_en.
  logic [63:0] sram [0:127];
  always @(posedge clock) begin
    if (W0_en)
      for (int b = 0; b < 8; b++)
        if (W0_mask[b]) sram[W0_addr[6:0]][8*b +: 8] <= W0_data[8*b +: 8];
    if (R0_en) R0_data <= sram[R0_addr[6:0]];
  end

  typedef struct {
    logic [63:0] data;
    logic        write;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [63:0] ref_mem [0:127];
  int          n_checks = 0;
  int          n_pass = 0;

  logic        obs_req_ready, obs_rsp_valid, obs_rsp_write, obs_rsp_err, obs_w0_en, obs_r0_en;
  logic [63:0] obs_rsp_data, obs_w0_data;
  logic [24:0] obs_w0_addr, obs_r0_addr;
  logic [7:0]  obs_w0_mask;
  logic        exp_ready, exp_rsp_valid, exp_w0, exp_r0;
  exp_t        exp_head;

  // One bus cycle: drive at negedge, sample 1ns later, advance the model at the posedge.
  task automatic cycle(input logic v, input logic wr, input logic [24:0] a,
                       input logic [63:0] d, input logic [7:0] m, input logic rr);
    logic err;
    logic acc;
    exp_t e;
    @(negedge clock);
    req_valid = v; req_write = wr; req_addr = a; req_data = d; req_mask = m; rsp_ready = rr;
    #1;
    obs_req_ready = req_ready; obs_rsp_valid = rsp_valid; obs_rsp_data = rsp_data;
    obs_rsp_write = rsp_write; obs_rsp_err = rsp_err; obs_w0_en = W0_en; obs_r0_en = R0_en;
    obs_w0_addr = W0_addr; obs_w0_data = W0_data; obs_w0_mask = W0_mask; obs_r0_addr = R0_addr;
    err = (a[24:7] != 18'd0);
    exp_ready = (q.size() < 2);
    exp_rsp_valid = (q.size() > 0);
    if (exp_rsp_valid) exp_head = q[0];
    else exp_head = '{data: 64'd0, write: 1'b0, err: 1'b0};
    acc = v && exp_ready;
    exp_w0 = acc && wr && !err;
    exp_r0 = acc && !wr && !err;
    @(posedge clock);
    if (exp_rsp_valid && rr) void'(q.pop_front());
    if (acc) begin
      e.write = wr;
      e.err = err;
      e.data = (wr || err) ? 64'd0 : ref_mem[a[6:0]];
      if (wr && !err)
        for (int b = 0; b < 8; b++)
          if (m[b]) ref_mem[a[6:0]][8*b +: 8] = d[8*b +: 8];
      q.push_back(e);
    end
  endtask

  task automatic test_reset;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 25'd3; req_data = '1; req_mask = '1; rsp_ready = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    n_checks++; if (W0_en !== 1'b0 || R0_en !== 1'b0) $display("FAIL reset_sram_en W0_en=%b R0_en=%b expected 0 0", W0_en, R0_en); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b expected 0", rsp_valid); else n_pass++;
    req_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b expected 1", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0 || W0_en !== 1'b0 || R0_en !== 1'b0)
      $display("FAIL reset_idle rsp_valid=%b W0_en=%b R0_en=%b expected 0 0 0", rsp_valid, W0_en, R0_en); else n_pass++;
  endtask

  task automatic test_write_read;
    cycle(1, 1, 25'h05, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1);
    n_checks++; if (obs_w0_en !== 1'b1 || obs_r0_en !== 1'b0) $display("FAIL wr_en W0_en=%b R0_en=%b expected 1 0", obs_w0_en, obs_r0_en); else n_pass++;
    n_checks++; if (obs_w0_addr !== 25'h05 || obs_w0_data !== 64'hDEADBEEF_CAFEF00D || obs_w0_mask !== 8'hFF)
      $display("FAIL wr_fields addr=%h data=%h mask=%h expected 05 deadbeefcafef00d ff", obs_w0_addr, obs_w0_data, obs_w0_mask); else n_pass++;
    cycle(1, 0, 25'h05, 64'd0, 8'h00, 1);
    n_checks++; if (obs_r0_en !== 1'b1 || obs_w0_en !== 1'b0 || obs_r0_addr !== 25'h05)
      $display("FAIL rd_en R0_en=%b W0_en=%b R0_addr=%h expected 1 0 05", obs_r0_en, obs_w0_en, obs_r0_addr); else n_pass++;
    n_checks++; if (obs_rsp_valid !== 1'b1 || obs_rsp_write !== 1'b1 || obs_rsp_data !== 64'd0)
      $display("FAIL wr_rsp valid=%b write=%b data=%h expected 1 1 0", obs_rsp_valid, obs_rsp_write, obs_rsp_data); else n_pass++;
    cycle(0, 0, 25'h0, 64'd0, 8'h00, 1);
    n_checks++; if (obs_rsp_valid !== 1'b1 || obs_rsp_data !== 64'hDEADBEEF_CAFEF00D || obs_rsp_write !== 1'b0 || obs_rsp_err !== 1'b0)
      $display("FAIL rd_rsp valid=%b data=%h write=%b err=%b expected 1 deadbeefcafef00d 0 0", obs_rsp_valid, obs_rsp_data, obs_rsp_write, obs_rsp_err); else n_pass++;
    n_checks++; if (obs_w0_en !== 1'b0 || obs_r0_en !== 1'b0) $display("FAIL idle_en W0_en=%b R0_en=%b expected 0 0", obs_w0_en, obs_r0_en); else n_pass++;
  endtask

  task automatic test_mask;
    cycle(1, 1, 25'h09, 64'd0, 8'hFF, 1);
    cycle(1, 1, 25'h09, 64'h11111111_22222222, 8'h0F, 1);
    cycle(1, 0, 25'h09, 64'd0, 8'h00, 1);
    cycle(0, 0, 25'h0, 64'd0, 8'h00, 1);
    n_checks++; if (obs_rsp_valid !== 1'b1 || obs_rsp_data !== 64'h00000000_22222222)
      $display("FAIL mask_rsp valid=%b data=%h expected 1 0000000022222222", obs_rsp_valid, obs_rsp_data); else n_pass++;
  endtask

  task automatic test_error;
    cycle(1, 0, 25'h80, 64'd0, 8'h00, 1);
    n_checks++; if (obs_r0_en !== 1'b0 || obs_w0_en !== 1'b0) $display("FAIL err_en R0_en=%b W0_en=%b expected 0 0", obs_r0_en, obs_w0_en); else n_pass++;
    cycle(1, 1, 25'h1000080, 64'hFFFF, 8'hFF, 1);
    n_checks++; if (obs_rsp_valid !== 1'b1 || obs_rsp_err !== 1'b1 || obs_rsp_data !== 64'd0 || obs_rsp_write !== 1'b0)
      $display("FAIL err_rsp valid=%b err=%b data=%h write=%b expected 1 1 0 0", obs_rsp_valid, obs_rsp_err, obs_rsp_data, obs_rsp_write); else n_pass++;
    n_checks++; if (obs_w0_en !== 1'b0) $display("FAIL err_wr_en W0_en=%b expected 0", obs_w0_en); else n_pass++;
    cycle(0, 0, 25'h0, 64'd0, 8'h00, 1);
    n_checks++; if (obs_rsp_err !== 1'b1 || obs_rsp_write !== 1'b1) $display("FAIL err_wr_rsp err=%b write=%b expected 1 1", obs_rsp_err, obs_rsp_write); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [24:0] addrs [3];
    int got;
    addrs[0] = 25'h05; addrs[1] = 25'h09; addrs[2] = 25'h05;
    cycle(1, 0, addrs[0], 64'd0, 8'h00, 0);
    cycle(1, 0, addrs[1], 64'd0, 8'h00, 0);
    n_checks++; if (obs_req_ready !== 1'b1) $display("FAIL bp_second_ready got %b expected 1", obs_req_ready); else n_pass++;
    cycle(1, 0, addrs[2], 64'd0, 8'h00, 0);
    n_checks++; if (obs_req_ready !== 1'b0) $display("FAIL bp_third_ready got %b expected 0", obs_req_ready); else n_pass++;
    n_checks++; if (obs_r0_en !== 1'b0) $display("FAIL bp_third_r0 got %b expected 0", obs_r0_en); else n_pass++;
    cycle(1, 0, addrs[2], 64'd0, 8'h00, 0);
    n_checks++; if (obs_rsp_valid !== 1'b1 || obs_rsp_data !== 64'hDEADBEEF_CAFEF00D)
      $display("FAIL bp_hold valid=%b data=%h expected 1 deadbeefcafef00d", obs_rsp_valid, obs_rsp_data); else n_pass++;
    got = 0;
    for (int i = 0; i < 6; i++) begin
      cycle((q.size() < 2 && got < 1) ? 1'b1 : 1'b0, 0, addrs[2], 64'd0, 8'h00, 1);
      if (obs_req_ready && req_valid) got++;
      n_checks++; if (obs_rsp_valid !== exp_rsp_valid || (exp_rsp_valid && obs_rsp_data !== exp_head.data))
        $display("FAIL bp_order cycle=%0d valid=%b data=%h expected %b %h", i, obs_rsp_valid, obs_rsp_data, exp_rsp_valid, exp_head.data); else n_pass++;
    end
    n_checks++; if (got != 1) $display("FAIL bp_third_accept count=%0d expected 1", got); else n_pass++;
  endtask

  task automatic test_streaming;
    int nrsp;
    nrsp = 0;
    for (int i = 0; i < 17; i++) begin
      cycle(i < 16, 0, 25'($urandom_range(0, 15)), 64'd0, 8'h00, 1);
      if (obs_rsp_valid) nrsp++;
      if (i < 16) begin
        n_checks++; if (obs_req_ready !== 1'b1) $display("FAIL stream_ready cycle=%0d got %b expected 1", i, obs_req_ready); else n_pass++;
      end
      if (i > 0) begin
        n_checks++; if (obs_rsp_valid !== 1'b1 || obs_rsp_data !== exp_head.data)
          $display("FAIL stream_rsp cycle=%0d valid=%b data=%h expected 1 %h", i, obs_rsp_valid, obs_rsp_data, exp_head.data); else n_pass++;
      end
    end
    n_checks++; if (nrsp != 16) $display("FAIL stream_count got %0d expected 16", nrsp); else n_pass++;
  endtask

  task automatic test_random;
    logic [24:0] a;
    for (int i = 0; i < 128; i++)
      cycle(1, 1, 25'(i), {$urandom, $urandom}, 8'hFF, 1);
    for (int i = 0; i < 400; i++) begin
      a = 25'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) a[24:7] = 18'($urandom_range(1, 262143));
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, {$urandom, $urandom},
            8'($urandom), $urandom_range(0, 9) < 7);
      n_checks++; if (obs_req_ready !== exp_ready) $display("FAIL rnd_ready cycle=%0d got %b expected %b", i, obs_req_ready, exp_ready); else n_pass++;
      n_checks++; if (obs_rsp_valid !== exp_rsp_valid) $display("FAIL rnd_rsp_valid cycle=%0d got %b expected %b", i, obs_rsp_valid, exp_rsp_valid); else n_pass++;
      if (exp_rsp_valid) begin
        n_checks++; if (obs_rsp_data !== exp_head.data || obs_rsp_write !== exp_head.write || obs_rsp_err !== exp_head.err)
          $display("FAIL rnd_head cycle=%0d data=%h w=%b e=%b expected %h %b %b", i, obs_rsp_data, obs_rsp_write, obs_rsp_err,
                   exp_head.data, exp_head.write, exp_head.err); else n_pass++;
      end
      n_checks++; if (obs_w0_en !== exp_w0 || obs_r0_en !== exp_r0)
        $display("FAIL rnd_sram_en cycle=%0d W0_en=%b R0_en=%b expected %b %b", i, obs_w0_en, obs_r0_en, exp_w0, exp_r0); else n_pass++;
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 25'h0, 64'd0, 8'h00, 1);
  endtask

  task automatic test_reset_mid;
    cycle(1, 0, 25'h05, 64'd0, 8'h00, 0);
    cycle(1, 0, 25'h09, 64'd0, 8'h00, 0);
    cycle(0, 0, 25'h0, 64'd0, 8'h00, 0);
    n_checks++; if (obs_rsp_valid !== 1'b1 || obs_req_ready !== 1'b0)
      $display("FAIL mid_full rsp_valid=%b req_ready=%b expected 1 0", obs_rsp_valid, obs_req_ready); else n_pass++;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL mid_rst_valid got %b expected 0", rsp_valid); else n_pass++;
    q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 25'h0, 64'd0, 8'h00, 1);
      n_checks++; if (obs_rsp_valid !== 1'b0 || obs_req_ready !== 1'b1 || obs_r0_en !== 1'b0)
        $display("FAIL mid_after cycle=%0d rsp_valid=%b req_ready=%b R0_en=%b expected 0 1 0", i, obs_rsp_valid, obs_req_ready, obs_r0_en); else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = 64'd0;
    end
    test_reset();
    test_write_read();
    test_mask();
    test_error();
    test_back_to_back();
    test_streaming();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // SRAM contents start at zero like the reference array; the macro has no reset of its own.
  initial begin
    for (int i = 0; i < 128; i++) sram[i] = 64'd0;
  end

endmodule
